// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves one conditional branch at a time and drives the fetch redirect.
//
// A request is captured in IDLE and compared in EVAL. A taken branch with an aligned target
// goes to REDIR, which holds redirect_valid/redirect_pc until fetch acknowledges. Every other
// outcome goes straight to RESP. RESP pulses resp_valid with the outcome flags for one cycle.
//
// Optional feature: define BRANCH_PERF_CNT_EN to add the CNT_W parameter, the branch_cnt and
// taken_cnt ports, and their counters. The default build leaves them out.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE, never while rst is high)
//   funct3, rs1, rs2         branch type and comparison operands
//   pc, imm                  branch PC and sign-extended B-immediate
//   redirect_valid/_pc/_ack  fetch redirect, held until acknowledged
//   flush                    one-cycle pulse on the first REDIR cycle
//   resp_valid, resp_taken, resp_illegal, resp_misalign   completion pulse and outcome flags
//   branch_cnt, taken_cnt    performance counters (BRANCH_PERF_CNT_EN only)
module branch_ctrl #(
  parameter int unsigned XLEN  = 32
`ifdef BRANCH_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ack,
  output logic            flush,
  output logic            resp_valid,
  output logic            resp_taken,
  output logic            resp_illegal,
  output logic            resp_misalign
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StEval, StRedir, StResp} state_e;

  state_e state_q, state_d;

  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;
  logic            misalign_q, misalign_d;
  logic            redir_first_q, redir_first_d;

  // Evaluation of the captured operands; only consumed while in EVAL.
  logic            eq, lt, taken, illegal, misalign;
  logic [XLEN-1:0] target;

  always_comb begin
    eq       = (rs1_q == rs2_q);
    // funct3[1] selects the unsigned compare (BLTU/BGEU).
    lt       = funct3_q[1] ? (rs1_q < rs2_q) : ($signed(rs1_q) < $signed(rs2_q));
    target   = pc_q + imm_q;
    illegal  = 1'b0;
    taken    = 1'b0;
    unique case (funct3_q)
      3'b000:         taken = eq;
      3'b001:         taken = !eq;
      3'b100, 3'b110: taken = lt;
      3'b101, 3'b111: taken = !lt;
      default:        illegal = 1'b1;
    endcase
    misalign = taken && (target[1:0] != 2'b00);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StEval;
      StEval:  state_d = (taken && !misalign) ? StRedir : StResp;
      StRedir: if (redirect_ack) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    funct3_d   = funct3_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    taken_d    = taken_q;
    illegal_d  = illegal_q;
    misalign_d = misalign_q;
    if (state_q == StIdle && req_valid) begin
      funct3_d = funct3;
      rs1_d    = rs1;
      rs2_d    = rs2;
      pc_d     = pc;
      imm_d    = imm;
    end
    if (state_q == StEval) begin
      taken_d    = taken;
      illegal_d  = illegal;
      misalign_d = misalign;
    end
    redir_first_d = (state_q == StEval) && (state_d == StRedir);
    // redirect_pc only moves on a real redirect and otherwise keeps its last value.
    redirect_pc_d = redir_first_d ? target : redirect_pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_q      <= 3'b000;
      rs1_q         <= '0;
      rs2_q         <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      redirect_pc_q <= '0;
      taken_q       <= 1'b0;
      illegal_q     <= 1'b0;
      misalign_q    <= 1'b0;
      redir_first_q <= 1'b0;
    end else begin
      funct3_q      <= funct3_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      redirect_pc_q <= redirect_pc_d;
      taken_q       <= taken_d;
      illegal_q     <= illegal_d;
      misalign_q    <= misalign_d;
      redir_first_q <= redir_first_d;
    end
  end

  // Outputs are decoded from state so an asynchronous reset clears them at once.
  always_comb begin
    req_ready      = (state_q == StIdle) && !rst;
    redirect_valid = (state_q == StRedir);
    flush          = redirect_valid && redir_first_q;
    redirect_pc    = redirect_pc_q;
    resp_valid     = (state_q == StResp);
    resp_taken     = resp_valid && taken_q;
    resp_illegal   = resp_valid && illegal_q;
    resp_misalign  = resp_valid && misalign_q;
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (state_q == StResp && !illegal_q) branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (state_q == StResp && taken_q)    taken_cnt_d  = taken_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
`endif

endmodule
